// File: rtl/design_25_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package design_25_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int DEF_W       = 8;
  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 4;

  // Requester index width; never narrower than one bit.
  function automatic int calcIdw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/design_25_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after i_ptr, wrapping N-1 -> 0.
module design_25_sched_rr_arbiter
  import design_25_sched_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = calcIdw(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_winner,
  output logic           o_any
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    o_gnt    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_winner     = w_idx;
      end
    end
  end

endmodule

// File: rtl/design_25_sched.sv
// Shares one registered adder among N requesters: grant, issue one start, await valid,
// return the tagged sum; aborts on timeout and flags latency violations.
module design_25_sched
  import design_25_sched_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IDW    = calcIdw(N)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_req_a,
  input  logic [N*W-1:0] i_req_b,
  output logic [N-1:0]   o_gnt,
  output logic           o_rsp_valid,
  output logic [IDW-1:0] o_rsp_id,
  output logic [W-1:0]   o_rsp_y,
  output logic           o_rsp_err,
  output logic           o_lat_err,
  output logic           o_add_start,
  output logic [W-1:0]   o_add_a,
  output logic [W-1:0]   o_add_b,
  input  logic [W-1:0]   i_add_y,
  input  logic           i_add_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  sched_state_e   r_state;
  sched_state_e   w_nextState;
  logic [IDW-1:0] r_rrPtr;
  logic [IDW-1:0] r_curId;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_addA;
  logic [W-1:0]   r_addB;
  logic           r_rspValid;
  logic [IDW-1:0] r_rspId;
  logic [W-1:0]   r_rspY;
  logic           r_rspErr;
  logic           r_latErr;
  logic [N-1:0]   w_arbGnt;
  logic [IDW-1:0] w_winner;
  logic           w_any;
  logic           w_timeout;

  design_25_sched_rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .i_req    (i_req),
    .i_ptr    (r_rrPtr),
    .o_gnt    (w_arbGnt),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:  if (w_any) w_nextState = ISSUE;
      ISSUE: w_nextState = WAIT;
      WAIT: begin
        if (i_add_valid) begin
          w_nextState = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Grants are only offered while idle, so a response cycle can also accept the next op.
  assign o_gnt       = (r_state == IDLE) ? w_arbGnt : '0;
  assign o_add_start = (r_state == ISSUE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rrPtr    <= '0;
      r_curId    <= '0;
      r_cnt      <= '0;
      r_addA     <= '0;
      r_addB     <= '0;
      r_rspValid <= 1'b0;
      r_rspId    <= '0;
      r_rspY     <= '0;
      r_rspErr   <= 1'b0;
      r_latErr   <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      if (i_add_valid && (r_state != WAIT)) r_latErr <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_addA  <= i_req_a[int'(w_winner)*W +: W];
            r_addB  <= i_req_b[int'(w_winner)*W +: W];
            r_curId <= w_winner;
            r_rrPtr <= (int'(w_winner) == N - 1) ? '0 : w_winner + IDW'(1);
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (i_add_valid) begin
            r_rspValid <= 1'b1;
            r_rspY     <= i_add_y;
            r_rspId    <= r_curId;
            r_rspErr   <= 1'b0;
          end else if (w_timeout) begin
            r_rspValid <= 1'b1;
            r_rspY     <= '0;
            r_rspId    <= r_curId;
            r_rspErr   <= 1'b1;
            r_latErr   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = r_rspValid;
  assign o_rsp_id    = r_rspId;
  assign o_rsp_y     = r_rspY;
  assign o_rsp_err   = r_rspErr;
  assign o_lat_err   = r_latErr;
  assign o_add_a     = r_addA;
  assign o_add_b     = r_addB;

endmodule

// File: tb/tb_design_25_sched.sv
// Scheduler bench: a registered adder stand-in behind the DUT and a transaction-level
// timing model (grant -> start +1 -> response +3, or +2+TIMEOUT when the adder stays silent).
module tb_design_25_sched;

  localparam int W       = 8;
  localparam int N       = 4;
  localparam int TIMEOUT = 4;
  localparam int IDW     = 2;
  localparam int NEVER   = 32'h7fff_ffff;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] reqA  = '0;
  logic [N*W-1:0] reqB  = '0;
  logic [N-1:0]   gnt;
  logic           rspValid;
  logic [IDW-1:0] rspId;
  logic [W-1:0]   rspY;
  logic           rspErr;
  logic           latErr;
  logic           addStart;
  logic [W-1:0]   addA;
  logic [W-1:0]   addB;
  logic [W-1:0]   addY;
  logic           addValid;
  logic           mdlValid;
  logic [W-1:0]   mdlY;
  logic           killAdd     = 1'b0;
  logic           injectValid = 1'b0;

  always #5 clk = ~clk;

  // Registered adder stand-in; killAdd suppresses its valid to provoke a timeout.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdlValid <= 1'b0;
      mdlY     <= '0;
    end else begin
      mdlValid <= addStart && !killAdd;
      mdlY     <= addA + addB;
    end
  end

  assign addValid = mdlValid | injectValid;
  assign addY     = mdlY;

  design_25_sched #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_a     (reqA),
    .i_req_b     (reqB),
    .o_gnt       (gnt),
    .o_rsp_valid (rspValid),
    .o_rsp_id    (rspId),
    .o_rsp_y     (rspY),
    .o_rsp_err   (rspErr),
    .o_lat_err   (latErr),
    .o_add_start (addStart),
    .o_add_a     (addA),
    .o_add_b     (addB),
    .i_add_y     (addY),
    .i_add_valid (addValid)
  );

  int checkCount = 0;
  int errCount   = 0;
  int cyc        = 0;
  int freeAt, startAt, rspAt, latFrom, rrNext;
  logic [IDW-1:0] pendId, holdId, lastId;
  logic [W-1:0]   pendY, holdY, holdA, holdB, lastY;
  logic           pendErr, holdErr, lastErr;
  logic [N-1:0]   grantedNow;
  logic [N-1:0]   stageReq   = '0;
  logic [N*W-1:0] stageA     = '0;
  logic [N*W-1:0] stageB     = '0;
  bit             stageClear = 1'b0;
  int  mode = 0;
  bit  killRand = 1'b0, forceKill = 1'b0, injectRand = 1'b0, injectOnce = 1'b0;
  int  rspSeen;
  int  gntIds[$];
  int  gntCycles[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic resetModel();
    freeAt     = 0;
    startAt    = -100;
    rspAt      = -100;
    latFrom    = NEVER;
    rrNext     = 0;
    holdId     = '0;
    holdY      = '0;
    holdErr    = 1'b0;
    holdA      = '0;
    holdB      = '0;
    grantedNow = '0;
    rspSeen    = 0;
    gntIds.delete();
    gntCycles.delete();
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    stageReq[i]       = 1'b1;
    stageA[i*W +: W]  = a;
    stageB[i*W +: W]  = b;
  endtask

  task automatic newOps(input int i);
    reqA[i*W +: W] = W'($urandom);
    reqB[i*W +: W] = W'($urandom);
  endtask

  task automatic applyStimulus();
    injectValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grantedNow[i]) begin
        if (mode == 2) newOps(i);
        else           req[i] = 1'b0;
      end
    end
    if (stageClear) req = '0;
    stageClear = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (stageReq[i]) begin
        req[i]         = 1'b1;
        reqA[i*W +: W] = stageA[i*W +: W];
        reqB[i*W +: W] = stageB[i*W +: W];
      end
    end
    stageReq = '0;
    if (mode == 1) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            newOps(i);
          end
        end else if (!grantedNow[i] && $urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    if ((injectOnce || (injectRand && $urandom_range(0, 9) == 0)) &&
        (cyc >= freeAt || cyc == startAt)) begin
      injectValid = 1'b1;
      injectOnce  = 1'b0;
      if (cyc + 1 < latFrom) latFrom = cyc + 1;
    end
  endtask

  task automatic checkCycle();
    int w;
    logic [N-1:0] expGnt;
    w      = (cyc >= freeAt) ? pickWinner(req, rrNext) : -1;
    expGnt = '0;
    if (w >= 0) expGnt[w] = 1'b1;
    if (cyc == rspAt) begin
      holdY   = pendY;
      holdId  = pendId;
      holdErr = pendErr;
    end
    if (rspValid) begin
      rspSeen++;
      lastY   = rspY;
      lastId  = rspId;
      lastErr = rspErr;
    end
    if (gnt != '0) begin
      gntIds.push_back($clog2(gnt));
      gntCycles.push_back(cyc);
    end
    checkOutput("gnt",         32'(gnt),            32'(expGnt));
    checkOutput("gnt_onehot0", 32'($onehot0(gnt)),  32'(1));
    checkOutput("add_start",   32'(addStart),       32'(cyc == startAt));
    checkOutput("rsp_valid",   32'(rspValid),       32'(cyc == rspAt));
    checkOutput("rsp_id",      32'(rspId),          32'(holdId));
    checkOutput("rsp_y",       32'(rspY),           32'(holdY));
    checkOutput("rsp_err",     32'(rspErr),         32'(holdErr));
    checkOutput("lat_err",     32'(latErr),         32'(cyc >= latFrom));
    checkOutput("add_a",       32'(addA),           32'(holdA));
    checkOutput("add_b",       32'(addB),           32'(holdB));
    grantedNow = expGnt;
    if (w >= 0) begin
      holdA   = reqA[w*W +: W];
      holdB   = reqB[w*W +: W];
      startAt = cyc + 1;
      pendId  = IDW'(w);
      rrNext  = (w + 1) % N;
      killAdd = forceKill || (killRand && $urandom_range(0, 3) == 0);
      if (killAdd) begin
        rspAt   = cyc + 2 + TIMEOUT;
        pendY   = '0;
        pendErr = 1'b1;
        if (rspAt < latFrom) latFrom = rspAt;
      end else begin
        rspAt   = cyc + 3;
        pendY   = W'((int'(holdA) + int'(holdB)) % (1 << W));
        pendErr = 1'b0;
      end
      freeAt = rspAt;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus();
    @(negedge clk);
    checkCycle();
  endtask

  task automatic doReset(input bit checkZero);
    rst_n       = 1'b0;
    req         = '0;
    injectValid = 1'b0;
    killAdd     = 1'b0;
    mode        = 0;
    injectOnce  = 1'b0;
    #1;
    if (checkZero) begin
      checkOutput("rst_gnt",       32'(gnt),      32'(0));
      checkOutput("rst_rsp_valid", 32'(rspValid), 32'(0));
      checkOutput("rst_rsp_id",    32'(rspId),    32'(0));
      checkOutput("rst_rsp_y",     32'(rspY),     32'(0));
      checkOutput("rst_rsp_err",   32'(rspErr),   32'(0));
      checkOutput("rst_lat_err",   32'(latErr),   32'(0));
      checkOutput("rst_add_start", 32'(addStart), 32'(0));
      checkOutput("rst_add_a",     32'(addA),     32'(0));
      checkOutput("rst_add_b",     32'(addB),     32'(0));
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
  endtask

  initial begin
    #2;
    doReset(1'b1);

    // Lone requester 2: 3 + 4.
    raise(2, 8'd3, 8'd4);
    repeat (6) stepCycle();
    checkOutput("t1_rsps", 32'(rspSeen), 32'(1));
    checkOutput("t1_id",   32'(lastId),  32'(2));
    checkOutput("t1_y",    32'(lastY),   32'(7));

    // All four held from a fresh pointer: 0,1,2,3,0 back to back.
    doReset(1'b0);
    mode = 2;
    for (int i = 0; i < N; i++) raise(i, W'($urandom), W'($urandom));
    repeat (16) stepCycle();
    checkOutput("t2_count", 32'(gntIds.size() >= 5), 32'(1));
    for (int k = 0; k < 5 && k < gntIds.size(); k++)
      checkOutput("t2_order", 32'(gntIds[k]), 32'(k % N));
    for (int k = 1; k < 5 && k < gntCycles.size(); k++)
      checkOutput("t2_gap", 32'(gntCycles[k] - gntCycles[k-1]), 32'(3));
    mode = 0;
    stageClear = 1'b1;
    repeat (8) stepCycle();

    // Wrapping sum from requester 3, then the pointer must wrap to 0.
    raise(3, 8'd200, 8'd100);
    repeat (5) stepCycle();
    checkOutput("t3_id",  32'(lastId),  32'(3));
    checkOutput("t3_y",   32'(lastY),   32'(44));
    checkOutput("t3_err", 32'(lastErr), 32'(0));
    gntIds.delete();
    raise(0, 8'd1, 8'd1);
    raise(1, 8'd2, 8'd2);
    repeat (4) stepCycle();
    checkOutput("t3_wrap_cnt", 32'(gntIds.size() >= 1), 32'(1));
    if (gntIds.size() >= 1) checkOutput("t3_wrap_id", 32'(gntIds[0]), 32'(0));
    stageClear = 1'b1;
    repeat (6) stepCycle();

    // Silent adder: timeout response, sticky lat_err through a later good op.
    forceKill = 1'b1;
    raise(1, 8'd5, 8'd6);
    repeat (9) stepCycle();
    forceKill = 1'b0;
    checkOutput("t4_err", 32'(lastErr), 32'(1));
    checkOutput("t4_y",   32'(lastY),   32'(0));
    checkOutput("t4_lat", 32'(latErr),  32'(1));
    raise(2, 8'd10, 8'd20);
    repeat (5) stepCycle();
    checkOutput("t4_good_y",   32'(lastY),   32'(30));
    checkOutput("t4_good_err", 32'(lastErr), 32'(0));
    checkOutput("t4_good_lat", 32'(latErr),  32'(1));

    // Spurious valid while idle.
    doReset(1'b0);
    injectOnce = 1'b1;
    repeat (3) stepCycle();
    checkOutput("t5_lat",  32'(latErr),  32'(1));
    checkOutput("t5_rsps", 32'(rspSeen), 32'(0));
    raise(0, 8'h55, 8'h22);
    repeat (5) stepCycle();
    checkOutput("t5_y",  32'(lastY),  32'(8'h77));
    checkOutput("t5_id", 32'(lastId), 32'(0));

    // Reset while waiting on the adder, then pointer restarts at 0.
    raise(3, 8'd9, 8'd9);
    repeat (3) stepCycle();
    doReset(1'b1);
    raise(1, 8'd1, 8'd2);
    raise(3, 8'd4, 8'd4);
    repeat (5) stepCycle();
    checkOutput("t6_cnt", 32'(gntIds.size() >= 1), 32'(1));
    if (gntIds.size() >= 1) checkOutput("t6_id", 32'(gntIds[0]), 32'(1));
    checkOutput("t6_y", 32'(lastY), 32'(3));
    stageClear = 1'b1;
    repeat (8) stepCycle();

    // Random traffic with occasional silent adder and spurious valids.
    doReset(1'b0);
    mode       = 1;
    killRand   = 1'b1;
    injectRand = 1'b1;
    repeat (600) stepCycle();
    mode       = 0;
    killRand   = 1'b0;
    injectRand = 1'b0;
    stageClear = 1'b1;
    repeat (10) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
